fc_input_writer: RTL and testbench



---
 rtl/fc_pkg.sv | 23 ++
 rtl/bram_sdp.sv | 49 ++++
 rtl/fc_input_writer.sv | 139 +++++++++++++
 tb/tb_fc_input_writer.sv | 391 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and sizing helpers for the dense-layer input path.
// Used by the input writer, its BRAM and the dense layer itself.
package fc_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ARM    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_FRAC_BITS  = 8;

    function automatic int fc_in_dim(input int c, input int h, input int w);
        return c * h * w;
    endfunction

    // Address width with a floor of one bit so tiny configs stay legal.
    function automatic int fc_aw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port block RAM: one write port, one read-first read port.
// Ports: clk, rst_n, we/waddr/wdata (write), re/raddr (read), rq (registered data).
module bram_sdp
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 16,
    localparam int AW        = fc_aw(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rq
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rq_d;
    logic [DATA_WIDTH-1:0] rq_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read samples the array before this edge's write lands: read-first.
    always_comb begin
        rq_d = rq_q;
        if (re) begin
            rq_d = mem[raddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_q <= '0;
        end else begin
            rq_q <= rq_d;
        end
    end

    assign rq = rq_q;

endmodule

// File: rtl/fc_input_writer.sv
// Fills the dense layer's input BRAM in channel-major flatten order,
// pulses start per frame, serves reads, and locks until dense_release.
// Ports: clk, reset_n, s_valid/s_ready/s_data/s_last (activation stream),
// start, dense_release (consumer handshake), rd_addr/rd_en/rd_q (read port),
// busy, frame_err.
module fc_input_writer
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int CHANNELS   = 8,
    parameter int HEIGHT     = 14,
    parameter int WIDTH      = 14,
    localparam int IN_DIM    = fc_in_dim(CHANNELS, HEIGHT, WIDTH),
    localparam int HW        = HEIGHT * WIDTH,
    localparam int AW        = fc_aw(IN_DIM)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_data,
    input  logic                         s_last,
    output logic                         start,
    input  logic                         dense_release,
    input  logic [AW-1:0]                rd_addr,
    input  logic                         rd_en,
    output logic signed [DATA_WIDTH-1:0] rd_q,
    output logic                         busy,
    output logic                         frame_err
);

    localparam int PW = fc_aw(HW);
    localparam int CW = fc_aw(CHANNELS);

    state_t        state_q, state_d;
    logic [CW-1:0] c_q, c_d;
    logic [PW-1:0] pix_q, pix_d;
    logic [AW-1:0] chan_off_q, chan_off_d;
    logic          s_ready_q, s_ready_d;
    logic          start_q, start_d;
    logic          busy_q, busy_d;
    logic          ferr_q, ferr_d;

    logic          accept;
    logic          last_chan;
    logic          last_beat;
    logic [AW-1:0] waddr;
    logic [DATA_WIDTH-1:0] rq;

    // s_ready is only ever high in FILL, so it alone gates acceptance.
    assign accept    = s_valid && s_ready_q;
    assign last_chan = (c_q == CW'(CHANNELS - 1));
    assign last_beat = last_chan && (pix_q == PW'(HW - 1));
    // chan_off tracks c*HW incrementally so no multiplier sits here.
    assign waddr     = chan_off_q + AW'(pix_q);

    always_comb begin
        state_d    = state_q;
        c_d        = c_q;
        pix_d      = pix_q;
        chan_off_d = chan_off_q;
        ferr_d     = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    ferr_d = s_last ^ last_beat;
                    if (last_chan) begin
                        c_d        = '0;
                        chan_off_d = '0;
                        pix_d      = last_beat ? '0 : pix_q + 1'b1;
                    end else begin
                        c_d        = c_q + 1'b1;
                        chan_off_d = chan_off_q + AW'(HW);
                    end
                    if (last_beat) begin
                        state_d = ARM;
                    end
                end
            end
            ARM: begin
                state_d = LOCKED;
            end
            LOCKED: begin
                if (dense_release) begin
                    state_d = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
        s_ready_d = (state_d == FILL);
        start_d   = (state_d == ARM);
        busy_d    = (state_d != FILL);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= FILL;
            c_q        <= '0;
            pix_q      <= '0;
            chan_off_q <= '0;
            s_ready_q  <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            c_q        <= c_d;
            pix_q      <= pix_d;
            chan_off_q <= chan_off_d;
            s_ready_q  <= s_ready_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            ferr_q     <= ferr_d;
        end
    end

    bram_sdp #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (IN_DIM)
    ) u_mem (
        .clk  (clk),
        .rst_n(reset_n),
        .we   (accept),
        .waddr(waddr),
        .wdata(s_data),
        .re   (rd_en),
        .raddr(rd_addr),
        .rq   (rq)
    );

    assign s_ready   = s_ready_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = ferr_q;
    assign rd_q      = rq;

endmodule

// File: tb/tb_fc_input_writer.sv
// Self-checking bench for fc_input_writer with C=2, H=2, W=3 (IN_DIM=12).
// Read expectations flow through a scoreboard queue fed by a memory model.
module tb_fc_input_writer;

    localparam int DW = 16;
    localparam int C  = 2;
    localparam int H  = 2;
    localparam int W  = 3;
    localparam int N  = C * H * W;
    localparam int AW = 4;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_data;
    logic                 s_last;
    logic                 start;
    logic                 dense_release;
    logic [AW-1:0]        rd_addr;
    logic                 rd_en;
    logic signed [DW-1:0] rd_q;
    logic                 busy;
    logic                 frame_err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cnt = 0;
    int ferr_cnt = 0;
    int start_cycs[$];
    int ferr_cycs[$];
    int last_acc = 0;
    logic [DW-1:0] model_mem [N];
    logic [DW-1:0] exp_q[$];

    fc_input_writer #(
        .DATA_WIDTH(DW),
        .CHANNELS  (C),
        .HEIGHT    (H),
        .WIDTH     (W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .start        (start),
        .dense_release(dense_release),
        .rd_addr      (rd_addr),
        .rd_en        (rd_en),
        .rd_q         (rd_q),
        .busy         (busy),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (start === 1'b1) begin
            start_cnt++;
            start_cycs.push_back(cyc);
        end
        if (frame_err === 1'b1) begin
            ferr_cnt++;
            ferr_cycs.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int beat_addr(input int k);
        return (k % C) * (H * W) + k / C;
    endfunction

    // Presents one beat after up to max_idle bubble cycles; updates the model.
    task automatic send_beat(input int k, input int d, input logic last,
                             input int max_idle);
        int n;
        s_valid = 1'b0;
        repeat ($urandom_range(0, max_idle)) begin
            @(posedge clk); #1;
        end
        s_valid = 1'b1;
        s_data  = DW'(d);
        s_last  = last;
        n = 0;
        while (s_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (s_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: s_ready=%b required 1", s_ready);
        end else begin
            last_acc = cyc;
            @(posedge clk); #1;
            model_mem[beat_addr(k)] = DW'(d);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic issue_read(input int a, output logic [DW-1:0] got,
                              output logic [DW-1:0] expv);
        exp_q.push_back(model_mem[a]);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        @(posedge clk); #1;
        rd_en = 1'b0;
        got   = rd_q;
        expv  = exp_q.pop_front();
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        dense_release = 1'b0; rd_en = 1'b0; rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, start, busy, frame_err} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: rdy/start/busy/ferr=%b required 0000",
                     {s_ready, start, busy, frame_err});
        end
        checks++;
        if (rd_q !== '0) begin
            errors++;
            $display("FAIL reset_rdq: got %0d required 0", rd_q);
        end
        reset_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: s_ready=%b busy=%b required 1 0",
                     s_ready, busy);
        end
    endtask

    task automatic test_frame;
        int s0, f0;
        s0 = start_cnt; f0 = ferr_cnt;
        for (int k = 0; k < N; k++) send_beat(k, k, (k == N - 1), 0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (start_cnt - s0 != 1) begin
            errors++;
            $display("FAIL frame_start_cnt: got %0d required 1", start_cnt - s0);
        end
        checks++;
        if (start_cycs.size() == 0 || start_cycs[$] != last_acc + 1) begin
            errors++;
            $display("FAIL frame_start_time: got %0d required %0d",
                     start_cycs.size() ? start_cycs[$] : -1, last_acc + 1);
        end
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL frame_locked: busy=%b s_ready=%b required 1 0",
                     busy, s_ready);
        end
        checks++;
        if (ferr_cnt != f0) begin
            errors++;
            $display("FAIL frame_no_err: got %0d pulses required 0", ferr_cnt - f0);
        end
    endtask

    task automatic test_reads;
        logic [DW-1:0] got, expv, held;
        int addrs [5];
        addrs = '{7, 0, 6, 11, 2};
        issue_read(7, got, expv);
        checks++;
        if (got !== 16'd3) begin
            errors++;
            $display("FAIL rd7_beat3: got %0d required 3", got);
        end
        for (int i = 0; i < 5; i++) begin
            issue_read(addrs[i], got, expv);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL rd_addr%0d: got %0d required %0d", addrs[i], got, expv);
            end
        end
        held = got;
        rd_addr = AW'(5);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rd_q !== held) begin
            errors++;
            $display("FAIL rd_hold: got %0d required %0d", rd_q, held);
        end
    endtask

    task automatic test_locked;
        logic [DW-1:0] got, expv;
        s_valid = 1'b1; s_data = 16'sd99;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            errors++;
            $display("FAIL locked_ready: got %b required 0", s_ready);
        end
        s_valid = 1'b0;
        issue_read(7, got, expv);
        checks++;
        if (got !== expv || got !== 16'd3) begin
            errors++;
            $display("FAIL locked_nowrite: got %0d required 3", got);
        end
        dense_release = 1'b1;
        @(posedge clk); #1;
        dense_release = 1'b0;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL release_ready: s_ready=%b busy=%b required 1 0",
                     s_ready, busy);
        end
        send_beat(0, 50, 1'b0, 0);
        issue_read(0, got, expv);
        checks++;
        if (got !== expv || got !== 16'd50) begin
            errors++;
            $display("FAIL refill_addr0: got %0d required 50", got);
        end
    endtask

    // Continues the frame begun by test_locked; s_last misplaced.
    task automatic test_frame_err;
        int s0, f0, acc5;
        logic [DW-1:0] got, expv;
        s0 = start_cnt; f0 = ferr_cnt; acc5 = 0;
        for (int k = 1; k < N; k++) begin
            send_beat(k, 200 + k, (k == 5), 0);
            if (k == 5) acc5 = last_acc;
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ferr_cnt - f0 != 2) begin
            errors++;
            $display("FAIL ferr_cnt: got %0d required 2", ferr_cnt - f0);
        end
        checks++;
        if (ferr_cycs.size() < 2 || ferr_cycs[$-1] != acc5 + 1
            || ferr_cycs[$] != last_acc + 1) begin
            errors++;
            $display("FAIL ferr_time: got %0d,%0d required %0d,%0d",
                     ferr_cycs.size() > 1 ? ferr_cycs[$-1] : -1,
                     ferr_cycs.size() > 0 ? ferr_cycs[$] : -1,
                     acc5 + 1, last_acc + 1);
        end
        checks++;
        if (start_cnt - s0 != 1 || start_cycs[$] != last_acc + 1) begin
            errors++;
            $display("FAIL ferr_start: count %0d required 1", start_cnt - s0);
        end
        issue_read(7, got, expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL ferr_rd7: got %0d required %0d", got, expv);
        end
    endtask

    task automatic test_reset_locked;
        int s0;
        s0 = start_cnt;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rst_locked: busy=%b s_ready=%b required 0 0",
                     busy, s_ready);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (s_ready !== 1'b1 || start_cnt != s0) begin
            errors++;
            $display("FAIL rst_locked_after: s_ready=%b starts=%0d required 1 0",
                     s_ready, start_cnt - s0);
        end
    endtask

    task automatic test_reset_mid;
        int s0;
        logic [DW-1:0] got, expv;
        for (int k = 0; k < 5; k++) send_beat(k, 300 + k, 1'b0, 1);
        #2 reset_n = 1'b0;
        #3 reset_n = 1'b1;
        @(posedge clk); #1;
        s0 = start_cnt;
        for (int k = 0; k < N; k++) begin
            send_beat(k, 100 + k, (k == N - 1), 3);
            if (k == N - 2) begin
                checks++;
                if (start_cnt != s0) begin
                    errors++;
                    $display("FAIL mid_early_start: got %0d required 0",
                             start_cnt - s0);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (start_cnt - s0 != 1 || start_cycs[$] != last_acc + 1) begin
            errors++;
            $display("FAIL mid_start: count %0d required 1", start_cnt - s0);
        end
        issue_read(1, got, expv);
        checks++;
        if (got !== expv || got !== 16'd102) begin
            errors++;
            $display("FAIL mid_rd1: got %0d required 102", got);
        end
        issue_read(4, got, expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL mid_rd4: got %0d required %0d", got, expv);
        end
    endtask

    task automatic test_release_ignored;
        int s0;
        logic [DW-1:0] got, expv;
        dense_release = 1'b1;
        @(posedge clk); #1;
        s0 = start_cnt;
        for (int k = 0; k < N; k++) send_beat(k, 400 + k, (k == N - 1), 2);
        @(posedge clk); #1;
        dense_release = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL rel_locked: busy=%b s_ready=%b required 1 0",
                     busy, s_ready);
        end
        checks++;
        if (start_cnt - s0 != 1 || start_cycs[$] != last_acc + 1) begin
            errors++;
            $display("FAIL rel_start: count %0d required 1", start_cnt - s0);
        end
        for (int a = 0; a < N; a++) begin
            issue_read(a, got, expv);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL rel_rd%0d: got %0d required %0d", a, got, expv);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) model_mem[i] = 'x;
        test_reset();
        test_frame();
        test_reads();
        test_locked();
        test_frame_err();
        test_reset_locked();
        test_reset_mid();
        test_release_ignored();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
